i2s_fir_eq: RTL and testbench

- Stereo 8-tap FIR equaliser directly downstream of the I2S receiver.
- Consumes its 24-bit left/right sample pair and single-cycle valid pulse.
- Filters both channels with one time-shared multiplier, using a hard-coded coefficient bank chosen by eq_sel.
- Outputs a filtered stereo pair with a one-cycle valid pulse for the output/DSP stage.

---
 rtl/i2s_fir_eq.sv | 160 ++++++++++++++++
 tb/tb_i2s_fir_eq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_fir_eq.sv
// Stereo 8-tap FIR equaliser behind the I2S receiver. Each channel keeps its own
// delay line; a single multiplier is shared, running left taps first and then right taps.

module i2s_fir_eq_line #(
    parameter int DATA_W = 24,
    parameter int NTAPS  = 8,
    parameter int IDX_W  = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     shift,
    input  logic        [DATA_W-1:0] din,
    input  logic        [IDX_W-1:0]  idx,
    output logic signed [DATA_W-1:0] tap
);
    // x[0] holds the newest sample
    logic [NTAPS-1:0][DATA_W-1:0] x;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     x <= '0;
        else if (shift) x <= {x[NTAPS-2:0], din};
    end

    assign tap = x[idx];
endmodule

module i2s_fir_eq #(
    parameter int DATA_W = 24,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 44,
    parameter int NTAPS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_left,
    input  logic [DATA_W-1:0] in_right,
    input  logic              in_valid,
    input  logic [1:0]        eq_sel,
    output logic [DATA_W-1:0] out_left,
    output logic [DATA_W-1:0] out_right,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun
);
    localparam int IDX_W  = $clog2(NTAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int FRAC   = COEF_W - 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MAC_L = 2'd1;
    localparam logic [1:0] MAC_R = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1 << (FRAC - 1));
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic [1:0]                state;
    logic [IDX_W-1:0]          idx;
    logic [1:0]                bank;
    logic signed [ACC_W-1:0]   acc_l, acc_r;
    logic                      accept;
    logic [1:0][DATA_W-1:0]    din;
    logic [1:0][DATA_W-1:0]    taps;
    logic signed [DATA_W-1:0]  tap_sel;
    logic signed [COEF_W-1:0]  h_sel;
    logic signed [PROD_W-1:0]  prod;

    function automatic logic signed [COEF_W-1:0] coef(input logic [1:0] b, input logic [IDX_W-1:0] k);
        case (b)
            2'd0: return (k == '0) ? COEF_W'(16384) : COEF_W'(0);
            2'd1: return COEF_W'(2048);
            2'd2: begin
                case (k)
                    3'd0, 3'd7: return COEF_W'(512);
                    3'd1, 3'd6: return COEF_W'(1536);
                    3'd2, 3'd5: return COEF_W'(2560);
                    default:    return COEF_W'(3584);
                endcase
            end
            default: return (k == '0) ? COEF_W'(14336) : COEF_W'(-2048);
        endcase
    endfunction

    // Round half up, drop the Q2.14 fraction, clamp to the sample range
    function automatic logic [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] sh;
        sh = (a + RND) >>> FRAC;
        if (sh > SAT_MAX)      sh = SAT_MAX;
        else if (sh < SAT_MIN) sh = SAT_MIN;
        return sh[DATA_W-1:0];
    endfunction

    assign accept = (state == IDLE) && in_valid;
    assign busy   = (state != IDLE);
    assign din    = {in_right, in_left};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        i2s_fir_eq_line #(
            .DATA_W (DATA_W),
            .NTAPS  (NTAPS),
            .IDX_W  (IDX_W)
        ) u_line (
            .clk   (clk),
            .reset (reset),
            .shift (accept),
            .din   (din[ch]),
            .idx   (idx),
            .tap   (taps[ch])
        );
    end

    assign tap_sel = (state == MAC_R) ? taps[1] : taps[0];
    assign h_sel   = coef(bank, idx);
    assign prod    = PROD_W'(tap_sel) * PROD_W'(h_sel);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            bank      <= '0;
            acc_l     <= '0;
            acc_r     <= '0;
            out_left  <= '0;
            out_right <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid && busy) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bank  <= eq_sel;
                        acc_l <= '0;
                        acc_r <= '0;
                        idx   <= '0;
                        state <= MAC_L;
                    end
                end
                MAC_L: begin
                    acc_l <= acc_l + ACC_W'(prod);
                    idx   <= idx + 1'b1;
                    if (idx == IDX_W'(NTAPS - 1)) state <= MAC_R;
                end
                MAC_R: begin
                    acc_r <= acc_r + ACC_W'(prod);
                    idx   <= idx + 1'b1;
                    if (idx == IDX_W'(NTAPS - 1)) state <= DONE;
                end
                default: begin
                    out_left  <= sat(acc_l);
                    out_right <= sat(acc_r);
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2s_fir_eq.sv
// Bench for i2s_fir_eq: directed cases plus random pairs against a plain-arithmetic
// convolution model of the equaliser.

module tb_i2s_fir_eq;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [23:0] in_left = '0, in_right = '0;
    logic        in_valid = 1'b0;
    logic [1:0]  eq_sel = '0;
    logic [23:0] out_left, out_right;
    logic        out_valid, busy, overrun;

    i2s_fir_eq dut (
        .clk       (clk),
        .reset     (reset),
        .in_left   (in_left),
        .in_right  (in_right),
        .in_valid  (in_valid),
        .eq_sel    (eq_sel),
        .out_left  (out_left),
        .out_right (out_right),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int          n_assert = 0, n_fail = 0;
    longint      hl[8], hr[8];
    int          bank_m = 0;
    logic [23:0] exp_l, exp_r;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint coef(input int b, input int k);
        longint lp[8];
        lp = '{512, 1536, 2560, 3584, 3584, 2560, 1536, 512};
        case (b)
            0: return (k == 0) ? 16384 : 0;
            1: return 2048;
            2: return lp[k];
            default: return (k == 0) ? 14336 : -2048;
        endcase
    endfunction

    // y = sat(round(sum h[k]*x[k] / 2^14))
    function automatic logic [23:0] model(input bit right);
        longint acc, r;
        acc = 0;
        for (int k = 0; k < 8; k++) acc += coef(bank_m, k) * (right ? hr[k] : hl[k]);
        r = (acc + 8192) >>> 14;
        if (r > 8388607)  r = 8388607;
        if (r < -8388608) r = -8388608;
        return r[23:0];
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 8; k++) begin hl[k] = 0; hr[k] = 0; end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        clear_model();
        tick();
    endtask

    // Presents a pair in IDLE and passes the accepting edge; model updated with expectations.
    task automatic start_pair(input logic [23:0] l, input logic [23:0] r, input int sel);
        in_left  = l;
        in_right = r;
        eq_sel   = 2'(sel);
        in_valid = 1'b1;
        for (int k = 7; k > 0; k--) begin hl[k] = hl[k-1]; hr[k] = hr[k-1]; end
        hl[0]  = longint'(signed'(l));
        hr[0]  = longint'(signed'(r));
        bank_m = sel;
        exp_l  = model(1'b0);
        exp_r  = model(1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    // done = clock edges already passed since the accepting edge (1 right after start_pair)
    task automatic finish_pair(input string tag, input int done);
        int j;
        int busy_lo;
        j = done;
        busy_lo = 0;
        while (!out_valid && j < 40) begin
            if (!busy) busy_lo++;
            tick();
            j++;
        end
        check({tag, " latency"}, 32'(j), 32'd18);
        check({tag, " busy"}, 32'(busy_lo), 32'd0);
        check({tag, " left"}, {8'd0, out_left}, {8'd0, exp_l});
        check({tag, " right"}, {8'd0, out_right}, {8'd0, exp_r});
        check({tag, " busy_end"}, {31'd0, busy}, 32'd0);
        tick();
        check({tag, " vld_drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        logic [23:0] lp_exp [9];
        lp_exp = '{24'd31, 24'd94, 24'd156, 24'd219, 24'd219, 24'd156, 24'd94, 24'd31, 24'd0};
        clear_model();

        // reset state
        tick();
        check("rst out_left", {8'd0, out_left}, 32'd0);
        check("rst out_right", {8'd0, out_right}, 32'd0);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (out_left !== 0 || out_right !== 0 || out_valid !== 0 || busy !== 0 || overrun !== 0) bad++;
        end
        check("idle quiet", 32'(bad), 32'd0);

        // identity bank
        start_pair(24'h123456, 24'hFFFFFB, 0);
        finish_pair("bank0", 1);
        check("bank0 const l", {8'd0, out_left}, 32'h123456);
        check("bank0 const r", {8'd0, out_right}, 32'hFFFFFB);

        // lowpass impulse response
        do_reset();
        for (int i = 0; i < 9; i++) begin
            start_pair((i == 0) ? 24'd1000 : 24'd0, 24'd0, 2);
            finish_pair("bank2", 1);
            check($sformatf("lp imp %0d", i), {8'd0, out_left}, {8'd0, lp_exp[i]});
            repeat (236) tick();
        end

        // moving average step
        do_reset();
        for (int i = 0; i < 8; i++) begin
            start_pair(24'd4096, 24'd4096, 1);
            finish_pair("bank1", 1);
            check($sformatf("avg step %0d", i), {8'd0, out_left}, 32'(512 * (i + 1)));
            repeat (236) tick();
        end

        // highpass saturation
        do_reset();
        for (int i = 0; i < 8; i++) begin
            start_pair((i == 7) ? 24'h800000 : 24'h7FFFFF, 24'd0, 3);
            finish_pair("bank3", 1);
            repeat (236) tick();
        end
        check("hp sat", {8'd0, out_left}, 32'h800000);

        // overrun: second pair mid-computation dropped, eq_sel change ignored
        do_reset();
        start_pair(24'd8000, 24'hFFF000, 1);
        repeat (4) tick();
        in_left = 24'h3FFFFF; in_right = 24'h3FFFFF; eq_sel = 2'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("ovr set", {31'd0, overrun}, 32'd1);
        finish_pair("overrun", 6);
        check("ovr avg", {8'd0, out_left}, 32'd1000);
        repeat (50) tick();
        check("ovr sticky", {31'd0, overrun}, 32'd1);

        // in_valid during DONE dropped, next cycle accepted
        do_reset();
        start_pair(24'd5000, 24'd7000, 2);
        repeat (16) tick();
        in_left = 24'h555555; in_right = 24'h555555; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("done vld", {31'd0, out_valid}, 32'd1);
        check("done l", {8'd0, out_left}, {8'd0, exp_l});
        check("done r", {8'd0, out_right}, {8'd0, exp_r});
        check("done ovr", {31'd0, overrun}, 32'd1);
        start_pair(24'd9000, 24'hFFFF00, 2);
        finish_pair("after done", 1);

        // reset mid-computation aborts the pair
        do_reset();
        start_pair(24'd1234, 24'd4321, 0);
        repeat (8) tick();
        reset = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort l", {8'd0, out_left}, 32'd0);
        check("abort r", {8'd0, out_right}, 32'd0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid !== 0) bad++;
        end
        reset = 1'b1;
        clear_model();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid !== 0) bad++;
        end
        check("abort no vld", 32'(bad), 32'd0);
        start_pair(24'd8000, 24'd16000, 1);
        finish_pair("post abort", 1);
        check("post abort l", {8'd0, out_left}, 32'd1000);
        check("post abort r", {8'd0, out_right}, 32'd2000);

        // random pairs and banks
        for (int i = 0; i < 40; i++) begin
            start_pair(24'($urandom), 24'($urandom), int'($urandom_range(0, 3)));
            finish_pair($sformatf("rand %0d", i), 1);
            repeat ($urandom_range(0, 5)) tick();
        end
        check("rand no ovr", {31'd0, overrun}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
